// File: rtl/bounded_updown_counter_pkg.sv
// Shared types and elaboration-time helpers for the bounded up/down counter.
// Mode encoding and the bound-legality check live here so every file agrees.
package bounded_updown_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_t;

    // Legal iff LO < HI and HI is representable in WIDTH bits.
    function automatic bit bounds_ok(input int width, input int lo, input int hi);
        longint max_val;
        max_val = (longint'(1) << width) - 1;
        return (lo >= 0) && (lo < hi) && (longint'(hi) <= max_val);
    endfunction

endpackage

// File: rtl/bounded_updown_counter_step_calc.sv
// Next-count arithmetic for the bounded counter: one signed-free step of es
// in either direction, folded back into [LO, HI] by wrapping or clipping.
module bounded_step_calc
    import bounded_updown_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LO    = 3,
    parameter int HI    = 12
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH+1:0] es,
    input  logic             up_down,
    input  count_mode_t      mode,
    output logic [WIDTH-1:0] next,
    output logic             wrapped,
    output logic             clipped
);

    // Two spare bits cover q + N and LO + es without overflow since N <= 2**WIDTH.
    localparam int XW = WIDTH + 2;
    localparam logic [XW-1:0] LO_X = XW'(LO);
    localparam logic [XW-1:0] HI_X = XW'(HI);
    localparam logic [XW-1:0] N_X  = XW'(HI - LO + 1);

    logic [XW-1:0] q_x;
    logic [XW-1:0] up_sum;
    logic [XW-1:0] up_wrap;
    logic [XW-1:0] dn_diff;
    logic [XW-1:0] dn_wrap;
    logic          over;
    logic          under;
    logic [XW-1:0] next_x;

    assign q_x     = XW'(q);
    assign up_sum  = q_x + es;
    assign up_wrap = up_sum - N_X;
    // Underflow tested as LO + es > q so the subtraction below never goes negative.
    assign under   = (LO_X + es) > q_x;
    assign over    = up_sum > HI_X;
    assign dn_diff = q_x - es;
    assign dn_wrap = q_x + N_X - es;

    always_comb begin
        next_x  = q_x;
        wrapped = 1'b0;
        clipped = 1'b0;
        if (up_down) begin
            if (!over) begin
                next_x = up_sum;
            end else if (mode == MODE_WRAP) begin
                next_x  = up_wrap;
                wrapped = 1'b1;
            end else begin
                next_x  = HI_X;
                clipped = 1'b1;
            end
        end else begin
            if (!under) begin
                next_x = dn_diff;
            end else if (mode == MODE_WRAP) begin
                next_x  = dn_wrap;
                wrapped = 1'b1;
            end else begin
                next_x  = LO_X;
                clipped = 1'b1;
            end
        end
    end

    assign next = WIDTH'(next_x);

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter over [LO, HI] with wrap/saturate modes, clamped
// parallel load and a sticky out-of-range load flag.
module bounded_updown_counter
    import bounded_updown_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LO     = 3,
    parameter int HI     = 12,
    parameter int STEP_W = WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic              mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic              at_min,
    output logic              at_max,
    output logic              wrap_p,
    output logic              sat_p,
    output logic              load_err
);

    generate
        if (!bounds_ok(WIDTH, LO, HI)) begin : g_bad_bounds
            $error("bounded_updown_counter: need LO < HI <= 2**WIDTH-1");
        end
    endgenerate

    localparam int N  = HI - LO + 1;
    // Compare step against N at whichever width is larger so neither side truncates.
    localparam int CW = (STEP_W > WIDTH + 2) ? STEP_W : WIDTH + 2;
    localparam logic [WIDTH-1:0] LO_Q = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_Q = WIDTH'(HI);
    localparam logic [CW-1:0]    N_C  = CW'(N);

    logic [CW-1:0]    step_c;
    logic [CW-1:0]    es_c;
    logic [WIDTH+1:0] es;
    logic [WIDTH-1:0] next;
    logic             wrapped;
    logic             clipped;
    logic             count;
    logic             d_low;
    logic             d_high;
    logic [WIDTH-1:0] load_val;
    count_mode_t      mode_e;

    assign mode_e = count_mode_t'(mode);
    assign step_c = CW'(step);
    assign es_c   = (step_c > N_C) ? N_C : step_c;
    assign es     = (WIDTH + 2)'(es_c);
    assign count  = en && (step != '0);

    assign d_low    = d < LO_Q;
    assign d_high   = d > HI_Q;
    assign load_val = d_low ? LO_Q : (d_high ? HI_Q : d);

    bounded_step_calc #(
        .WIDTH (WIDTH),
        .LO    (LO),
        .HI    (HI)
    ) u_calc (
        .q       (q),
        .es      (es),
        .up_down (up_down),
        .mode    (mode_e),
        .next    (next),
        .wrapped (wrapped),
        .clipped (clipped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= LO_Q;
            wrap_p   <= 1'b0;
            sat_p    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap_p <= 1'b0;
            sat_p  <= 1'b0;
            if (load) begin
                q <= load_val;
            end else if (count) begin
                q      <= next;
                wrap_p <= wrapped;
                sat_p  <= clipped;
            end
            // An erroneous load beats a same-cycle clear.
            if (load && (d_low || d_high)) begin
                load_err <= 1'b1;
            end else if (clr_err) begin
                load_err <= 1'b0;
            end
        end
    end

    assign at_min = (q == LO_Q);
    assign at_max = (q == HI_Q);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares
// after each rising edge. Directed scenarios first, then random traffic.
module tb_bounded_updown_counter;

    localparam int WIDTH  = 4;
    localparam int LO     = 3;
    localparam int HI     = 12;
    localparam int STEP_W = 4;
    localparam int N      = HI - LO + 1;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             at_min;
        logic             at_max;
        logic             wrap_p;
        logic             sat_p;
        logic             load_err;
    } obs_t;

    logic              clk = 1'b0;
    logic              reset, en, up_down, mode, load, clr_err;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  d, q;
    logic              at_min, at_max, wrap_p, sat_p, load_err;

    obs_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   mq      = LO;
    bit   merr    = 1'b0;

    always #5 clk = ~clk;

    bounded_updown_counter #(
        .WIDTH (WIDTH), .LO (LO), .HI (HI), .STEP_W (STEP_W)
    ) dut (
        .clk (clk), .reset (reset), .en (en), .up_down (up_down), .mode (mode),
        .step (step), .load (load), .d (d), .clr_err (clr_err), .q (q),
        .at_min (at_min), .at_max (at_max), .wrap_p (wrap_p), .sat_p (sat_p),
        .load_err (load_err)
    );

    // Reference: counting is modular arithmetic on the offset from LO, or a clamp.
    task automatic apply(input bit r, input bit ld, input int dv, input bit e,
                         input bit ud, input bit md, input int st, input bit c);
        obs_t x;
        bit   w = 0, s = 0;
        int   es, t;
        @(negedge clk);
        reset = r; load = ld; d = WIDTH'(dv); en = e; up_down = ud;
        mode = md; step = STEP_W'(st); clr_err = c;
        if (r) begin
            mq = LO; merr = 0;
        end else begin
            if (ld) begin
                if (dv < LO)      mq = LO;
                else if (dv > HI) mq = HI;
                else              mq = dv;
            end else if (e && st != 0) begin
                es = (st < N) ? st : N;
                t  = ud ? mq + es : mq - es;
                if (!md) begin
                    w  = (t > HI) || (t < LO);
                    mq = LO + ((((t - LO) % N) + N) % N);
                end else if (t > HI) begin
                    mq = HI; s = 1;
                end else if (t < LO) begin
                    mq = LO; s = 1;
                end else begin
                    mq = t;
                end
            end
            if (ld && (dv < LO || dv > HI)) merr = 1;
            else if (c)                     merr = 0;
        end
        x.q = WIDTH'(mq); x.at_min = (mq == LO); x.at_max = (mq == HI);
        x.wrap_p = w; x.sat_p = s; x.load_err = merr;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{q, at_min, at_max, wrap_p, sat_p, load_err};
                vectors++;
                if (a !== e || (wrap_p && sat_p)) begin
                    errors++;
                    $display("FAIL vec%0d: got q=%0d min=%b max=%b wrap=%b sat=%b err=%b, expected q=%0d min=%b max=%b wrap=%b sat=%b err=%b",
                             vectors, a.q, a.at_min, a.at_max, a.wrap_p, a.sat_p, a.load_err,
                             e.q, e.at_min, e.at_max, e.wrap_p, e.sat_p, e.load_err);
                end
            end
        end
    end

    initial begin : driver
        reset = 1; load = 0; d = '0; en = 0; up_down = 0; mode = 0; step = '0; clr_err = 0;
        // reset then idle
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(0, 0, 0, 0, 0, 0, 1, 0);
        // WRAP up from HI, then confirm single-cycle pulse
        apply(0, 1, 12, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 1, 0, 1, 0);
        apply(0, 0, 0, 0, 1, 0, 1, 0);
        // WRAP down step 4 from 5
        apply(0, 1, 5, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 4, 0);
        apply(0, 0, 0, 0, 0, 0, 4, 0);
        // SATURATE up from 10, then again at the bound
        apply(0, 1, 10, 0, 1, 1, 0, 0);
        apply(0, 0, 0, 1, 1, 1, 5, 0);
        apply(0, 0, 0, 1, 1, 1, 1, 0);
        apply(0, 0, 0, 1, 0, 1, 15, 0);
        apply(0, 0, 0, 1, 0, 1, 1, 0);
        // out-of-range loads, load beats count, clear
        apply(0, 1, 14, 0, 1, 0, 0, 0);
        apply(0, 1, 2, 1, 1, 0, 3, 0);
        apply(0, 0, 0, 0, 1, 0, 0, 1);
        apply(0, 1, 0, 0, 1, 0, 0, 1);
        apply(0, 0, 0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0, 1);
        // oversized step and zero step
        apply(0, 1, 7, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 1, 0, 15, 0);
        apply(0, 0, 0, 1, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 15, 0);
        // reset overrides a simultaneous load and count
        apply(0, 0, 0, 1, 1, 0, 2, 0);
        apply(1, 1, 9, 1, 1, 0, 2, 0);
        apply(0, 0, 0, 1, 1, 0, 2, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15)),
                  $urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        en = 0; load = 0; reset = 0; clr_err = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bounded_updown_counter.md
BOUNDED_UPDOWN_COUNTER -- requirements
Module: bounded_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 The block SHALL have parameter LO, default 3, lower count bound (inclusive).
REQ-003 The block SHALL have parameter HI, default 12, upper count bound (inclusive); N = HI-LO+1.
REQ-004 The block SHALL have parameter STEP_W, default WIDTH, width of the step input.
REQ-005 The block SHALL have the port clk, input, 1 bit, the clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit, synchronous, active-high reset.
REQ-007 The block SHALL have the port en, input, 1 bit, count enable.
REQ-008 The block SHALL have the port up_down, input, 1 bit: 1 = count up, 0 = count down.
REQ-009 The block SHALL have the port mode, input, 1 bit: 0 = WRAP, 1 = SATURATE.
REQ-010 The block SHALL have the port step, input, STEP_W bits, the increment/decrement magnitude.
REQ-011 The block SHALL have the port load, input, 1 bit, synchronous parallel load enable.
REQ-012 The block SHALL have the port d, input, WIDTH bits, the parallel load value.
REQ-013 The block SHALL have the port clr_err, input, 1 bit, which clears load_err.
REQ-014 The block SHALL have the port q, output, WIDTH bits, registered count.
REQ-015 The block SHALL have the port at_min / at_max, output, 1 bit each, combinational: q==LO / q==HI.
REQ-016 The block SHALL have the port wrap_p, output, 1 bit, registered one-cycle pulse after a wrapping count.
REQ-017 The block SHALL have the port sat_p, output, 1 bit, registered one-cycle pulse after a clipped count.
REQ-018 The block SHALL have the port load_err, output, 1 bit, sticky flag for an out-of-range load.

Function
REQ-019 Update priority SHALL be: reset > load > (en && step!=0) > hold.
REQ-020 Load SHALL set q=d if LO<=d<=HI; else q=LO (d<LO) or HI (d>HI), with load_err set in the same edge.
REQ-021 The effective step SHALL be es = min(step, N); step==0 with en=1 SHALL hold q with no pulses.
REQ-022 In WRAP up: q+es>HI SHALL give q+es-N with wrap_p=1 next cycle, else q+es.
REQ-023 In WRAP down: q-es<LO SHALL give q-es+N with wrap_p=1, else q-es.
REQ-024 In SATURATE: a result beyond HI/LO SHALL clip to HI/LO with sat_p=1; q already at the bound SHALL also clip and pulse.
REQ-025 Arithmetic SHALL use WIDTH+2-bit intermediates; no overflow is permitted for any legal parameter set.
REQ-026 wrap_p/sat_p SHALL be 0 on any cycle without a count (load, hold, en=0) and never both 1.
REQ-027 load_err SHALL clear on clr_err; simultaneous clr_err and an erroneous load SHALL leave load_err=1 (set wins).
REQ-028 mode, up_down and step SHALL be sampled per cycle; changes take effect on the next edge with no internal state.
REQ-029 Elaboration SHALL fail if LO>=HI or HI>2**WIDTH-1.

Reset
REQ-030 On reset: q=LO, wrap_p=0, sat_p=0, load_err=0; at_min=1, at_max=0 follow.
REQ-031 Reset mid-count SHALL override load/en on that edge; counting resumes from LO on the next enabled edge.

Structure
REQ-032 A shared package SHALL hold the count_mode_t enum (MODE_WRAP=0, MODE_SAT=1) and the parameter-check helper.
REQ-033 The next-value arithmetic SHALL live in one combinational sub-module, bounded_step_calc (inputs q, es, up_down, mode; outputs next, wrapped, clipped); the top holds only registers and priority.

Verification (defaults LO=3 HI=12 N=10)
REQ-034 The bench SHALL cover: reset, then en=0 for 3 cycles -> q=3, at_min=1, all pulses 0.
REQ-035 The bench SHALL cover: WRAP, up, step=1 from q=12 -> q=3, wrap_p=1 for exactly one cycle; step=4 down from q=5 -> q=11, wrap_p=1.
REQ-036 The bench SHALL cover: SATURATE, up, step=5 from q=10 -> q=12, sat_p=1; next up count -> q=12, sat_p=1 again.
REQ-037 The bench SHALL cover: load d=14 -> q=12, load_err=1; load d=2 with en=1 -> q=3 (load wins); clr_err -> load_err=0.
REQ-038 The bench SHALL cover: step=15 (>N) in WRAP up from q=7 -> q=7, wrap_p=1; step=0 with en=1 -> q unchanged, no pulse.
REQ-039 The bench SHALL cover: reset asserted together with load d=9 and en=1 -> q=3, load_err unchanged at 0.
